// File: rtl/piso_serializer_if.sv
// Handshake and serial-link signals between a word source and the PISO serializer.
// The source side uses the master modport; the serializer uses the slave modport.
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             ser_data;
   logic             ser_en;
   logic             busy;
   logic             word_done;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  ser_data,
      input  ser_en,
      input  busy,
      input  word_done
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output ser_data,
      output ser_en,
      output busy,
      output word_done
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: WIDTH-bit words go out MSB first, one bit per
// ser_en strobe, with a one-word holding register so consecutive words leave no gap.
module piso_serializer #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 1
) (
   input  logic             clk,
   input  logic             reset,
   piso_serializer_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic [WIDTH-1:0] hold_reg, hold_reg_d;
   logic             hold_valid, hold_valid_d;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
   logic [DIV_W-1:0] div_cnt, div_cnt_d;
   logic             accept;
   logic             bit_strobe;
   logic             last_bit;

   assign bus.in_ready = !hold_valid && !reset;
   assign accept       = bus.in_valid && bus.in_ready;
   assign bit_strobe   = (state == SHIFT) && (div_cnt == DIV_LAST);
   assign last_bit     = bit_strobe && (bit_cnt == CNT_ONE);

   // shreg is all zeros whenever the FSM is IDLE (every word is shifted fully out),
   // so its MSB can drive ser_data directly as a clean registered output.
   assign bus.ser_data  = shreg[WIDTH-1];
   assign bus.ser_en    = bit_strobe;
   assign bus.busy      = (state == SHIFT);
   assign bus.word_done = last_bit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         hold_reg   <= '0;
         hold_valid <= 1'b0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
      end else begin
         state      <= state_d;
         shreg      <= shreg_d;
         hold_reg   <= hold_reg_d;
         hold_valid <= hold_valid_d;
         bit_cnt    <= bit_cnt_d;
         div_cnt    <= div_cnt_d;
      end
   end

   always_comb begin
      state_d      = state;
      shreg_d      = shreg;
      hold_reg_d   = hold_reg;
      hold_valid_d = hold_valid;
      bit_cnt_d    = bit_cnt;
      div_cnt_d    = div_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               shreg_d   = bus.in_data;
               bit_cnt_d = CNT_FULL;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            div_cnt_d = bit_strobe ? '0 : div_cnt + DIV_ONE;
            if (bit_strobe) begin
               shreg_d   = {shreg[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt - CNT_ONE;
            end
            // Last bit: reload from the holding register first, then a fresh word,
            // so the next word's MSB follows without an idle bit.
            if (last_bit) begin
               if (hold_valid) begin
                  shreg_d      = hold_reg;
                  hold_valid_d = 1'b0;
                  bit_cnt_d    = CNT_FULL;
                  div_cnt_d    = '0;
               end else if (accept) begin
                  shreg_d   = bus.in_data;
                  bit_cnt_d = CNT_FULL;
                  div_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else if (accept) begin
               hold_reg_d   = bus.in_data;
               hold_valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (8b/div1, 8b/div3, 2b/div1)
// with SIPO receiver models that reassemble each word at its word_done strobe.
module tb_piso_serializer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   piso_serializer_if #(.WIDTH(8)) b8 ();
   piso_serializer_if #(.WIDTH(8)) b3 ();
   piso_serializer_if #(.WIDTH(2)) b2 ();

   piso_serializer #(.WIDTH(8), .CLK_DIV(1)) u8 (.clk(clk), .reset(reset), .bus(b8));
   piso_serializer #(.WIDTH(8), .CLK_DIV(3)) u3 (.clk(clk), .reset(reset), .bus(b3));
   piso_serializer #(.WIDTH(2), .CLK_DIV(1)) u2 (.clk(clk), .reset(reset), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SIPO receiver models
   logic [7:0] sipo8, sipo3;
   logic [1:0] sipo2;
   logic [7:0] word_q8[$];
   logic [7:0] word_q3[$];
   logic [1:0] word_q2[$];
   int         done8;

   initial begin
      sipo8 = '0; sipo3 = '0; sipo2 = '0; done8 = 0;
   end

   always @(negedge clk) begin
      if (b8.ser_en) begin
         if (b8.word_done) word_q8.push_back({sipo8[6:0], b8.ser_data});
         sipo8 = {sipo8[6:0], b8.ser_data};
      end
      if (b8.word_done) done8++;
      if (b3.ser_en) begin
         if (b3.word_done) word_q3.push_back({sipo3[6:0], b3.ser_data});
         sipo3 = {sipo3[6:0], b3.ser_data};
      end
      if (b2.ser_en) begin
         if (b2.word_done) word_q2.push_back({sipo2[0], b2.ser_data});
         sipo2 = {sipo2[0], b2.ser_data};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] bb [3];
      int         n0;
      int         d0;
      checks = 0;
      errors = 0;
      bb[0] = 8'h3C; bb[1] = 8'hC3; bb[2] = 8'hFF;
      reset = 1'b1;
      b8.in_valid = 1'b0; b8.in_data = '0;
      b3.in_valid = 1'b0; b3.in_data = '0;
      b2.in_valid = 1'b0; b2.in_data = '0;

      // reset state
      @(negedge clk);
      chk("rst_in_ready", b8.in_ready, 0);
      chk("rst_busy", b8.busy, 0);
      chk("rst_ser_en", b8.ser_en, 0);
      chk("rst_ser_data", b8.ser_data, 0);
      chk("rst_word_done", b8.word_done, 0);
      chk("rst_b3_in_ready", b3.in_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", b8.in_ready, 1);
      chk("post_rst_b2_in_ready", b2.in_ready, 1);

      // single word 0xA5, CLK_DIV=1
      w = 8'hA5;
      n0 = word_q8.size();
      b8.in_valid = 1'b1; b8.in_data = w;
      @(negedge clk);
      b8.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk("a5_ser_en", b8.ser_en, 1);
         chk("a5_ser_data", b8.ser_data, w[7-i]);
         chk("a5_word_done", b8.word_done, (i == 7));
         chk("a5_busy", b8.busy, 1);
      end
      @(negedge clk);
      chk("a5_busy_fall", b8.busy, 0);
      chk("a5_ser_en_off", b8.ser_en, 0);
      chk("a5_words", word_q8.size(), n0 + 1);
      chk("a5_sipo", word_q8[n0], 8'hA5);

      // single word 0x81, CLK_DIV=3
      w = 8'h81;
      n0 = word_q3.size();
      b3.in_valid = 1'b1; b3.in_data = w;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         b3.in_valid = 1'b0;
         if (c <= 24) begin
            chk("div3_ser_en", b3.ser_en, (c % 3 == 0));
            chk("div3_ser_data", b3.ser_data, w[7 - (c - 1) / 3]);
            chk("div3_word_done", b3.word_done, (c == 24));
         end else begin
            chk("div3_busy_fall", b3.busy, 0);
         end
      end
      chk("div3_words", word_q3.size(), n0 + 1);
      chk("div3_sipo", word_q3[n0], 8'h81);

      // back-to-back 0x3C, 0xC3, 0xFF with in_valid held; 0xFF meets backpressure
      n0 = word_q8.size();
      d0 = done8;
      b8.in_valid = 1'b1; b8.in_data = bb[0];
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (c <= 17)
            chk("b2b_in_ready", b8.in_ready, (c == 1 || c == 9 || c == 17));
         if (c <= 24) begin
            chk("b2b_ser_en", b8.ser_en, 1);
            w = bb[(c - 1) / 8];
            chk("b2b_ser_data", b8.ser_data, w[7 - (c - 1) % 8]);
            chk("b2b_word_done", b8.word_done, (c % 8 == 0));
         end else begin
            chk("b2b_busy_fall", b8.busy, 0);
         end
         if (c == 1) b8.in_data = bb[1];
         if (c == 2) b8.in_data = bb[2];
         if (c == 10) b8.in_valid = 1'b0;
      end
      chk("b2b_done_cnt", done8 - d0, 3);
      chk("b2b_words", word_q8.size(), n0 + 3);
      chk("b2b_sipo0", word_q8[n0], 8'h3C);
      chk("b2b_sipo1", word_q8[n0+1], 8'hC3);
      chk("bp_sipo2", word_q8[n0+2], 8'hFF);

      // reset after 3 of 8 bits of 0xF0
      w = 8'hF0;
      d0 = done8;
      b8.in_valid = 1'b1; b8.in_data = w;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         chk("abort_ser_data", b8.ser_data, w[8-c]);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_ser_en", b8.ser_en, 0);
      chk("abort_busy", b8.busy, 0);
      chk("abort_ser_data0", b8.ser_data, 0);
      chk("abort_word_done", b8.word_done, 0);
      chk("abort_in_ready", b8.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_in_ready_rel", b8.in_ready, 1);
      chk("abort_no_done", done8 - d0, 0);
      w = 8'h5A;
      n0 = word_q8.size();
      b8.in_valid = 1'b1; b8.in_data = w;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         if (c <= 8) begin
            chk("5a_ser_en", b8.ser_en, 1);
            chk("5a_ser_data", b8.ser_data, w[8-c]);
            chk("5a_word_done", b8.word_done, (c == 8));
         end
      end
      chk("5a_words", word_q8.size(), n0 + 1);
      chk("5a_sipo", word_q8[n0], 8'h5A);

      // WIDTH=2 stream 0b10, 0b01
      n0 = word_q2.size();
      b2.in_valid = 1'b1; b2.in_data = 2'b10;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c <= 4) begin
            chk("w2_ser_en", b2.ser_en, 1);
            chk("w2_ser_data", b2.ser_data, (c == 1 || c == 4));
            chk("w2_word_done", b2.word_done, (c == 2 || c == 4));
         end else begin
            chk("w2_busy_fall", b2.busy, 0);
         end
         if (c == 2) chk("w2_in_ready_full", b2.in_ready, 0);
         if (c == 1) b2.in_data = 2'b01;
         if (c == 2) b2.in_valid = 1'b0;
      end
      chk("w2_words", word_q2.size(), n0 + 2);
      chk("w2_sipo0", word_q2[n0], 2'b10);
      chk("w2_sipo1", word_q2[n0+1], 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
